// File: rtl/cc_neuron_loader_pkg.sv
// Shared constants for the neuron loader: state encoding,
// neuron fan-in and default word width.
package cc_neuron_loader_pkg;

  localparam int NUMBER_DATAWIDTH_DEF = 8;
  localparam int NEURON_INPUTS = 4;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOAD   = 2'd1;
  localparam logic [1:0] ST_EVAL   = 2'd2;
  localparam logic [1:0] ST_RESULT = 2'd3;

  function automatic logic [NEURON_INPUTS-1:0] slot_onehot(
    input logic [1:0] idx
  );
    logic [NEURON_INPUTS-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/cc_neuron_loader_if.sv
// Stream, neuron-bus and result signals of the neuron loader.
// master = parent/consumer side, slave = the loader.
interface cc_neuron_loader_if #(
  parameter int DW = cc_neuron_loader_pkg::NUMBER_DATAWIDTH_DEF
);
  logic          CC_NEURON_LOADER_start_In;
  logic [DW-1:0] CC_NEURON_LOADER_threshold_InBUS;
  logic          CC_NEURON_LOADER_clear_In;
  logic          CC_NEURON_LOADER_valid_In;
  logic [DW-1:0] CC_NEURON_LOADER_x_InBUS;
  logic [DW-1:0] CC_NEURON_LOADER_w_InBUS;
  logic          CC_NEURON_LOADER_ready_Out;
  logic [DW-1:0] CC_NEURON_LOADER_t0_OutBUS;
  logic [DW-1:0] CC_NEURON_LOADER_x0_OutBUS;
  logic [DW-1:0] CC_NEURON_LOADER_x1_OutBUS;
  logic [DW-1:0] CC_NEURON_LOADER_x2_OutBUS;
  logic [DW-1:0] CC_NEURON_LOADER_x3_OutBUS;
  logic [DW-1:0] CC_NEURON_LOADER_w0_OutBUS;
  logic [DW-1:0] CC_NEURON_LOADER_w1_OutBUS;
  logic [DW-1:0] CC_NEURON_LOADER_w2_OutBUS;
  logic [DW-1:0] CC_NEURON_LOADER_w3_OutBUS;
  logic          CC_NEURON_LOADER_y0_In;
  logic          CC_NEURON_LOADER_result_Out;
  logic          CC_NEURON_LOADER_resultValid_Out;
  logic          CC_NEURON_LOADER_ack_In;
  logic          CC_NEURON_LOADER_busy_Out;

  modport master (
    output CC_NEURON_LOADER_start_In,
    output CC_NEURON_LOADER_threshold_InBUS,
    output CC_NEURON_LOADER_clear_In,
    output CC_NEURON_LOADER_valid_In,
    output CC_NEURON_LOADER_x_InBUS,
    output CC_NEURON_LOADER_w_InBUS,
    output CC_NEURON_LOADER_y0_In,
    output CC_NEURON_LOADER_ack_In,
    input  CC_NEURON_LOADER_ready_Out,
    input  CC_NEURON_LOADER_t0_OutBUS,
    input  CC_NEURON_LOADER_x0_OutBUS,
    input  CC_NEURON_LOADER_x1_OutBUS,
    input  CC_NEURON_LOADER_x2_OutBUS,
    input  CC_NEURON_LOADER_x3_OutBUS,
    input  CC_NEURON_LOADER_w0_OutBUS,
    input  CC_NEURON_LOADER_w1_OutBUS,
    input  CC_NEURON_LOADER_w2_OutBUS,
    input  CC_NEURON_LOADER_w3_OutBUS,
    input  CC_NEURON_LOADER_result_Out,
    input  CC_NEURON_LOADER_resultValid_Out,
    input  CC_NEURON_LOADER_busy_Out
  );

  modport slave (
    input  CC_NEURON_LOADER_start_In,
    input  CC_NEURON_LOADER_threshold_InBUS,
    input  CC_NEURON_LOADER_clear_In,
    input  CC_NEURON_LOADER_valid_In,
    input  CC_NEURON_LOADER_x_InBUS,
    input  CC_NEURON_LOADER_w_InBUS,
    input  CC_NEURON_LOADER_y0_In,
    input  CC_NEURON_LOADER_ack_In,
    output CC_NEURON_LOADER_ready_Out,
    output CC_NEURON_LOADER_t0_OutBUS,
    output CC_NEURON_LOADER_x0_OutBUS,
    output CC_NEURON_LOADER_x1_OutBUS,
    output CC_NEURON_LOADER_x2_OutBUS,
    output CC_NEURON_LOADER_x3_OutBUS,
    output CC_NEURON_LOADER_w0_OutBUS,
    output CC_NEURON_LOADER_w1_OutBUS,
    output CC_NEURON_LOADER_w2_OutBUS,
    output CC_NEURON_LOADER_w3_OutBUS,
    output CC_NEURON_LOADER_result_Out,
    output CC_NEURON_LOADER_resultValid_Out,
    output CC_NEURON_LOADER_busy_Out
  );

endinterface

// File: rtl/cc_neuron_slot_reg.sv
// DW-bit holding register with async active-high reset
// and load enable; one per neuron bus word.
module cc_neuron_slot_reg #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic [DW-1:0] i_d,
  output logic [DW-1:0] o_q
);

  logic [DW-1:0] r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_q <= '0;
    else if (i_load)
      r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/cc_neuron_loader.sv
// Sequencer feeding a 4-input neuron: loads threshold and
// (x,w) pairs, evaluates one cycle, holds the decision until ack.
module cc_neuron_loader
  import cc_neuron_loader_pkg::*;
#(
  parameter int NUMBER_DATAWIDTH = NUMBER_DATAWIDTH_DEF
) (
  input logic               CC_NEURON_LOADER_CLOCK_50,
  input logic               CC_NEURON_LOADER_RESET_InHigh,
  cc_neuron_loader_if.slave bus
);

  localparam int DW = NUMBER_DATAWIDTH;

  logic       clk;
  logic       rst;
  logic [1:0] r_state;
  logic [1:0] r_count;
  logic       r_ready;
  logic       r_result;
  logic       r_valid;

  logic                     w_clear;
  logic                     w_start;
  logic                     w_accept;
  logic [NEURON_INPUTS-1:0] w_slot_en;
  logic [DW-1:0]            w_t0;
  logic [DW-1:0]            w_x [NEURON_INPUTS];
  logic [DW-1:0]            w_w [NEURON_INPUTS];

  assign clk = CC_NEURON_LOADER_CLOCK_50;
  assign rst = CC_NEURON_LOADER_RESET_InHigh;

  // clear outranks start and beats: no register loads on a clear cycle
  assign w_clear  = bus.CC_NEURON_LOADER_clear_In;
  assign w_start  = (r_state == ST_IDLE) &
                    bus.CC_NEURON_LOADER_start_In & ~w_clear;
  assign w_accept = r_ready & bus.CC_NEURON_LOADER_valid_In &
                    ~w_clear;
  assign w_slot_en = w_accept ? slot_onehot(r_count) : '0;

  cc_neuron_slot_reg #(.DW(DW)) u_t0 (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_start),
    .i_d    (bus.CC_NEURON_LOADER_threshold_InBUS),
    .o_q    (w_t0)
  );

  for (genvar g = 0; g < NEURON_INPUTS; g++) begin : g_slot
    cc_neuron_slot_reg #(.DW(DW)) u_x (
      .clk    (clk),
      .rst    (rst),
      .i_load (w_slot_en[g]),
      .i_d    (bus.CC_NEURON_LOADER_x_InBUS),
      .o_q    (w_x[g])
    );
    cc_neuron_slot_reg #(.DW(DW)) u_w (
      .clk    (clk),
      .rst    (rst),
      .i_load (w_slot_en[g]),
      .i_d    (bus.CC_NEURON_LOADER_w_InBUS),
      .o_q    (w_w[g])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_count  <= 2'd0;
      r_ready  <= 1'b0;
      r_result <= 1'b0;
      r_valid  <= 1'b0;
    end else if (w_clear) begin
      r_state <= ST_IDLE;
      r_count <= 2'd0;
      r_ready <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state <= ST_LOAD;
            r_count <= 2'd0;
            r_ready <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (w_accept) begin
            r_count <= r_count + 2'd1;
            if (r_count == 2'd3) begin
              r_state <= ST_EVAL;
              r_ready <= 1'b0;
            end
          end
        end
        ST_EVAL: begin
          r_result <= bus.CC_NEURON_LOADER_y0_In;
          r_valid  <= 1'b1;
          r_state  <= ST_RESULT;
        end
        ST_RESULT: begin
          if (bus.CC_NEURON_LOADER_ack_In) begin
            r_valid <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.CC_NEURON_LOADER_ready_Out       = r_ready;
  assign bus.CC_NEURON_LOADER_result_Out      = r_result;
  assign bus.CC_NEURON_LOADER_resultValid_Out = r_valid;
  assign bus.CC_NEURON_LOADER_busy_Out        = (r_state != ST_IDLE);
  assign bus.CC_NEURON_LOADER_t0_OutBUS       = w_t0;
  assign bus.CC_NEURON_LOADER_x0_OutBUS       = w_x[0];
  assign bus.CC_NEURON_LOADER_x1_OutBUS       = w_x[1];
  assign bus.CC_NEURON_LOADER_x2_OutBUS       = w_x[2];
  assign bus.CC_NEURON_LOADER_x3_OutBUS       = w_x[3];
  assign bus.CC_NEURON_LOADER_w0_OutBUS       = w_w[0];
  assign bus.CC_NEURON_LOADER_w1_OutBUS       = w_w[1];
  assign bus.CC_NEURON_LOADER_w2_OutBUS       = w_w[2];
  assign bus.CC_NEURON_LOADER_w3_OutBUS       = w_w[3];

endmodule

// File: tb/tb_cc_neuron_loader.sv
// Directed and randomized jobs for cc_neuron_loader with a
// job-level model of the loaded buses and the neuron decision.
module tb_cc_neuron_loader;
  import cc_neuron_loader_pkg::*;

  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  cc_neuron_loader_if #(.DW(DW)) ifc ();

  cc_neuron_loader #(.NUMBER_DATAWIDTH(DW)) dut (
    .CC_NEURON_LOADER_CLOCK_50     (clk),
    .CC_NEURON_LOADER_RESET_InHigh (rst),
    .bus                           (ifc.slave)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] bx [4];
  logic [DW-1:0] bw [4];
  logic [DW-1:0] bt;
  logic          rdy, res, rv, busy;

  assign bx[0] = ifc.CC_NEURON_LOADER_x0_OutBUS;
  assign bx[1] = ifc.CC_NEURON_LOADER_x1_OutBUS;
  assign bx[2] = ifc.CC_NEURON_LOADER_x2_OutBUS;
  assign bx[3] = ifc.CC_NEURON_LOADER_x3_OutBUS;
  assign bw[0] = ifc.CC_NEURON_LOADER_w0_OutBUS;
  assign bw[1] = ifc.CC_NEURON_LOADER_w1_OutBUS;
  assign bw[2] = ifc.CC_NEURON_LOADER_w2_OutBUS;
  assign bw[3] = ifc.CC_NEURON_LOADER_w3_OutBUS;
  assign bt    = ifc.CC_NEURON_LOADER_t0_OutBUS;
  assign rdy   = ifc.CC_NEURON_LOADER_ready_Out;
  assign res   = ifc.CC_NEURON_LOADER_result_Out;
  assign rv    = ifc.CC_NEURON_LOADER_resultValid_Out;
  assign busy  = ifc.CC_NEURON_LOADER_busy_Out;

  // neuron stand-in: y0 = (sum of x*w) > t0
  int nsum;
  always_comb begin
    nsum = 0;
    for (int i = 0; i < 4; i++)
      nsum = nsum + int'(bx[i]) * int'(bw[i]);
    ifc.CC_NEURON_LOADER_y0_In = (nsum > int'(bt));
  end

  logic [DW-1:0] mt;
  logic [DW-1:0] mx [4];
  logic [DW-1:0] mw [4];
  logic          mres;

  function automatic logic job_y();
    int s;
    s = 0;
    for (int i = 0; i < 4; i++)
      s += int'(mx[i]) * int'(mw[i]);
    return s > int'(mt);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] o,
                     input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, o, e);
    end
  endtask

  task automatic chk_bus(input string tag);
    chk({tag, ".t0"}, 32'(bt), 32'(mt));
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s.x%0d", tag, i), 32'(bx[i]), 32'(mx[i]));
      chk($sformatf("%s.w%0d", tag, i), 32'(bw[i]), 32'(mw[i]));
    end
  endtask

  task automatic chk_zero(input string tag);
    chk_bus(tag);
    chk({tag, ".res"}, 32'(res), 0);
    chk({tag, ".rv"}, 32'(rv), 0);
    chk({tag, ".rdy"}, 32'(rdy), 0);
    chk({tag, ".busy"}, 32'(busy), 0);
  endtask

  task automatic start_job(input logic [DW-1:0] t);
    ifc.CC_NEURON_LOADER_start_In = 1'b1;
    ifc.CC_NEURON_LOADER_threshold_InBUS = t;
    tick();
    ifc.CC_NEURON_LOADER_start_In = 1'b0;
    ifc.CC_NEURON_LOADER_threshold_InBUS = DW'($urandom);
    mt = t;
    chk("start.busy", 32'(busy), 1);
    chk("start.rdy", 32'(rdy), 1);
    chk("start.t0", 32'(bt), 32'(mt));
  endtask

  task automatic beat(input int i, input logic [DW-1:0] x,
                      input logic [DW-1:0] w, input int gap);
    for (int g = 0; g < gap; g++) begin
      ifc.CC_NEURON_LOADER_valid_In = 1'b0;
      ifc.CC_NEURON_LOADER_x_InBUS = DW'($urandom);
      ifc.CC_NEURON_LOADER_w_InBUS = DW'($urandom);
      tick();
      chk("gap.rdy", 32'(rdy), 1);
    end
    ifc.CC_NEURON_LOADER_valid_In = 1'b1;
    ifc.CC_NEURON_LOADER_x_InBUS = x;
    ifc.CC_NEURON_LOADER_w_InBUS = w;
    tick();
    ifc.CC_NEURON_LOADER_valid_In = 1'b0;
    mx[i] = x;
    mw[i] = w;
    chk($sformatf("beat%0d.rdy", i), 32'(rdy), (i < 3) ? 1 : 0);
  endtask

  // called right after the 4th beat edge (loader now in EVAL)
  task automatic finish_eval(input bit extra);
    chk("eval.rv", 32'(rv), 0);
    chk("eval.busy", 32'(busy), 1);
    if (extra) begin
      ifc.CC_NEURON_LOADER_valid_In = 1'b1;
      ifc.CC_NEURON_LOADER_x_InBUS = DW'($urandom);
      ifc.CC_NEURON_LOADER_w_InBUS = DW'($urandom);
    end
    tick();
    mres = job_y();
    chk("res.rv", 32'(rv), 1);
    chk("res.val", 32'(res), 32'(mres));
    chk_bus("res");
  endtask

  task automatic ack_job();
    ifc.CC_NEURON_LOADER_ack_In = 1'b1;
    tick();
    ifc.CC_NEURON_LOADER_ack_In = 1'b0;
    chk("ack.rv", 32'(rv), 0);
    chk("ack.busy", 32'(busy), 0);
    chk("ack.rdy", 32'(rdy), 0);
    chk("ack.res", 32'(res), 32'(mres));
  endtask

  task automatic rand_job(input int maxgap);
    start_job(DW'($urandom));
    for (int i = 0; i < 4; i++)
      beat(i, DW'($urandom), DW'($urandom),
           int'($urandom_range(maxgap, 0)));
    finish_eval(1'b0);
    ack_job();
  endtask

  task automatic model_reset();
    mt = '0;
    mres = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mx[i] = '0;
      mw[i] = '0;
    end
  endtask

  initial begin
    ifc.CC_NEURON_LOADER_start_In = 1'b0;
    ifc.CC_NEURON_LOADER_threshold_InBUS = '0;
    ifc.CC_NEURON_LOADER_clear_In = 1'b0;
    ifc.CC_NEURON_LOADER_valid_In = 1'b0;
    ifc.CC_NEURON_LOADER_x_InBUS = '0;
    ifc.CC_NEURON_LOADER_w_InBUS = '0;
    ifc.CC_NEURON_LOADER_ack_In = 1'b0;
    model_reset();

    #2;
    chk_zero("rst");
    tick();
    rst = 1'b0;
    tick();
    chk_zero("idle");

    // directed: sum 31 vs t0=50 -> 0
    start_job(8'd50);
    beat(0, 8'd2, 8'd3, 0);
    beat(1, 8'd4, 8'd5, 0);
    beat(2, 8'd1, 8'd1, 0);
    beat(3, 8'd2, 8'd2, 0);
    finish_eval(1'b0);
    chk("jobA.res", 32'(res), 0);
    ack_job();

    // same beats, t0=20 -> 1, held without ack
    start_job(8'd20);
    beat(0, 8'd2, 8'd3, 0);
    beat(1, 8'd4, 8'd5, 0);
    beat(2, 8'd1, 8'd1, 0);
    beat(3, 8'd2, 8'd2, 0);
    finish_eval(1'b0);
    chk("jobB.res", 32'(res), 1);
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("hold.rv", 32'(rv), 1);
      chk("hold.res", 32'(res), 1);
      chk_bus("hold");
    end
    ack_job();

    // gapped beats, valid kept high through EVAL/RESULT
    start_job(DW'($urandom));
    for (int i = 0; i < 4; i++)
      beat(i, DW'($urandom), DW'($urandom), 3);
    finish_eval(1'b1);
    for (int c = 0; c < 3; c++) begin
      ifc.CC_NEURON_LOADER_x_InBUS = DW'($urandom);
      tick();
      chk("rsv.rdy", 32'(rdy), 0);
      chk("rsv.rv", 32'(rv), 1);
      chk_bus("rsv");
    end
    ack_job();
    tick();
    chk("idlev.rdy", 32'(rdy), 0);
    chk("idlev.busy", 32'(busy), 0);
    chk_bus("idlev");
    ifc.CC_NEURON_LOADER_valid_In = 1'b0;

    // clear after 3 beats, with a beat and start offered too
    start_job(DW'($urandom));
    for (int i = 0; i < 3; i++)
      beat(i, DW'($urandom), DW'($urandom), 0);
    ifc.CC_NEURON_LOADER_clear_In = 1'b1;
    ifc.CC_NEURON_LOADER_valid_In = 1'b1;
    ifc.CC_NEURON_LOADER_start_In = 1'b1;
    ifc.CC_NEURON_LOADER_x_InBUS = DW'($urandom);
    tick();
    ifc.CC_NEURON_LOADER_clear_In = 1'b0;
    ifc.CC_NEURON_LOADER_valid_In = 1'b0;
    ifc.CC_NEURON_LOADER_start_In = 1'b0;
    chk("clr.busy", 32'(busy), 0);
    chk("clr.rdy", 32'(rdy), 0);
    chk("clr.rv", 32'(rv), 0);
    chk("clr.res", 32'(res), 32'(mres));
    chk_bus("clr");
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("clr2.rv", 32'(rv), 0);
      chk("clr2.busy", 32'(busy), 0);
    end
    rand_job(1);

    // start together with ack is dropped
    start_job(DW'($urandom));
    for (int i = 0; i < 4; i++)
      beat(i, DW'($urandom), DW'($urandom), 0);
    finish_eval(1'b0);
    ifc.CC_NEURON_LOADER_ack_In = 1'b1;
    ifc.CC_NEURON_LOADER_start_In = 1'b1;
    ifc.CC_NEURON_LOADER_threshold_InBUS = ~mt;
    tick();
    ifc.CC_NEURON_LOADER_ack_In = 1'b0;
    ifc.CC_NEURON_LOADER_start_In = 1'b0;
    chk("sa.busy", 32'(busy), 0);
    chk("sa.rv", 32'(rv), 0);
    chk("sa.t0", 32'(bt), 32'(mt));
    start_job(DW'($urandom));
    for (int i = 0; i < 4; i++)
      beat(i, DW'($urandom), DW'($urandom), 0);
    finish_eval(1'b0);
    ack_job();

    // async reset in the middle of LOAD
    start_job(DW'($urandom));
    beat(0, DW'($urandom), DW'($urandom), 0);
    beat(1, DW'($urandom), DW'($urandom), 0);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk_zero("arst");
    tick();
    chk_zero("arst2");
    rst = 1'b0;
    tick();
    chk_zero("arst3");

    for (int j = 0; j < 6; j++)
      rand_job(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
